// File: rtl/fd_corner_sink.sv
// FAST9 corner sink: splits refAddr into (x,y), drops border corners and queues
// accepted corners plus an end-of-frame marker for a ready/valid consumer.
module fd_corner_sink #(
    parameter int ADDR_W = 15,
    parameter int X_W    = 8,
    parameter int BORDER = 3,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inValid,
    input  logic                isCorner,
    input  logic [ADDR_W-1:0]   refAddr,
    input  logic                frameEnd,
    output logic                outValid,
    input  logic                outReady,
    output logic [X_W-1:0]      outX,
    output logic [ADDR_W-X_W-1:0] outY,
    output logic                outCorner,
    output logic                outLast,
    output logic [CNT_W-1:0]    frameCount,
    output logic                overflow,
    output logic                frameDone
);
    localparam int Y_W   = ADDR_W - X_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [X_W-1:0]   X_MIN = X_W'(BORDER);
    localparam logic [X_W-1:0]   X_MAX = X_W'((1 << X_W) - 1 - BORDER);
    localparam logic [Y_W-1:0]   Y_MIN = Y_W'(BORDER);
    localparam logic [Y_W-1:0]   Y_MAX = Y_W'((1 << Y_W) - 1 - BORDER);
    localparam logic [OCC_W-1:0] OCC_CORNER_MAX = OCC_W'(DEPTH - 2);
    localparam logic [OCC_W-1:0] OCC_LAST_MAX   = OCC_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic           last;
        logic           corner;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_cur_count;
    logic [CNT_W-1:0]   r_frame_count;
    logic               r_overflow;
    logic               r_frame_done;

    logic [X_W-1:0]     w_x;
    logic [Y_W-1:0]     w_y;
    logic               w_interior;
    logic               w_cand;
    logic               w_is_last;
    logic               w_want;
    logic               w_slot_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_out_vld;
    logic               w_acc_corner;
    logic [OCC_W-1:0]   w_occ_n;
    logic [CNT_W-1:0]   w_cur_inc;
    entry_t             w_entry;
    entry_t             w_head;

    assign w_x        = refAddr[X_W-1:0];
    assign w_y        = refAddr[ADDR_W-1:X_W];
    assign w_interior = (w_x >= X_MIN) && (w_x <= X_MAX) && (w_y >= Y_MIN) && (w_y <= Y_MAX);
    assign w_cand     = inValid & isCorner & w_interior;
    assign w_is_last  = inValid & frameEnd;
    assign w_want     = w_cand | w_is_last;

    assign w_out_vld  = (r_occ != '0);
    assign w_pop      = w_out_vld & outReady;
    assign w_occ_n    = r_occ - OCC_W'(w_pop);

    // Non-last corners leave one slot free so the frame marker always fits.
    assign w_slot_ok    = w_is_last ? (w_occ_n <= OCC_LAST_MAX) : (w_occ_n <= OCC_CORNER_MAX);
    assign w_push       = w_want & w_slot_ok;
    assign w_acc_corner = w_push & w_cand;
    assign w_cur_inc    = (r_cur_count == CNT_MAX) ? r_cur_count : r_cur_count + 1'b1;

    always_comb begin
        w_entry        = '0;
        w_entry.last   = w_is_last;
        w_entry.corner = w_cand;
        if (w_cand) begin
            w_entry.x = w_x;
            w_entry.y = w_y;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_occ         <= '0;
            r_cur_count   <= '0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ        <= w_occ_n + OCC_W'(w_push);
            r_frame_done <= w_pop & w_head.last;
            if (w_want && !w_slot_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_is_last) begin
                r_frame_count <= w_acc_corner ? w_cur_inc : r_cur_count;
                r_cur_count   <= '0;
            end else if (w_acc_corner) begin
                r_cur_count <= w_cur_inc;
            end
        end
    end

    // Head fields read straight from the storage flops; zeroed while empty.
    assign w_head     = w_out_vld ? r_mem[r_rd_ptr] : '0;
    assign outValid   = w_out_vld;
    assign outX       = w_head.x;
    assign outY       = w_head.y;
    assign outCorner  = w_head.corner;
    assign outLast    = w_head.last;
    assign frameCount = r_frame_count;
    assign overflow   = r_overflow;
    assign frameDone  = r_frame_done;
endmodule

// File: tb/tb_fd_corner_sink.sv
// Bench for fd_corner_sink: fixed vectors, directed corner cases and a
// randomized run against a queue-based model of the corner sink.
module tb_fd_corner_sink;
    localparam int DEPTH = 16;
    localparam int CMAX  = 65535;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        isCorner = 1'b0;
    logic [14:0] refAddr = '0;
    logic        frameEnd = 1'b0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [7:0]  outX;
    logic [6:0]  outY;
    logic        outCorner;
    logic        outLast;
    logic [15:0] frameCount;
    logic        overflow;
    logic        frameDone;

    fd_corner_sink dut (
        .clock(clock), .reset(reset), .inValid(inValid), .isCorner(isCorner),
        .refAddr(refAddr), .frameEnd(frameEnd), .outValid(outValid), .outReady(outReady),
        .outX(outX), .outY(outY), .outCorner(outCorner), .outLast(outLast),
        .frameCount(frameCount), .overflow(overflow), .frameDone(frameDone)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
        bit corner;
        bit last;
    } rec_t;

    rec_t mq[$];
    int   m_cur = 0;
    int   m_fcnt = 0;
    bit   m_ovf = 0;
    bit   m_fdone = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_cur = 0;
        m_fcnt = 0;
        m_ovf = 0;
        m_fdone = 0;
    endtask

    // Model: an ordered list of records; occupancy is simply its length.
    task automatic model_step(input bit v, input bit c, input int a, input bit fe, input bit rdy);
        int   x;
        int   y;
        int   occn;
        bit   interior;
        bit   cand;
        bit   is_last;
        bit   pop;
        bit   ok;
        rec_t r;
        x = a % 256;
        y = a / 256;
        interior = (x >= 3) && (x <= 252) && (y >= 3) && (y <= 124);
        cand = v && c && interior;
        is_last = v && fe;
        pop = (mq.size() > 0) && rdy;
        m_fdone = 0;
        if (pop) begin
            r = mq.pop_front();
            m_fdone = r.last;
        end
        occn = mq.size();
        ok = 0;
        if (cand || is_last) begin
            ok = is_last ? (occn <= DEPTH - 1) : (occn <= DEPTH - 2);
            if (ok) begin
                r.x = cand ? x : 0;
                r.y = cand ? y : 0;
                r.corner = cand;
                r.last = is_last;
                mq.push_back(r);
            end else begin
                m_ovf = 1;
            end
        end
        if (is_last) begin
            m_fcnt = m_cur + ((cand && ok) ? 1 : 0);
            if (m_fcnt > CMAX) m_fcnt = CMAX;
            m_cur = 0;
        end else if (cand && ok) begin
            m_cur = (m_cur + 1 > CMAX) ? CMAX : m_cur + 1;
        end
    endtask

    task automatic check_all();
        chk("outValid", int'(outValid), (mq.size() > 0) ? 1 : 0);
        if (mq.size() > 0) begin
            chk("outX", int'(outX), mq[0].x);
            chk("outY", int'(outY), mq[0].y);
            chk("outCorner", int'(outCorner), int'(mq[0].corner));
            chk("outLast", int'(outLast), int'(mq[0].last));
        end
        chk("frameCount", int'(frameCount), m_fcnt);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("frameDone", int'(frameDone), int'(m_fdone));
    endtask

    task automatic step(input bit v, input bit c, input int a, input bit fe, input bit rdy);
        inValid = v;
        isCorner = c;
        refAddr = 15'(a);
        frameEnd = fe;
        outReady = rdy;
        model_step(v, c, a, fe, rdy);
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        inValid = 0;
        frameEnd = 0;
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all();
    endtask

    typedef struct {
        int a;
        bit c;
        bit fe;
        bit vld;
        int x;
        int y;
        bit corner;
        bit last;
    } vec_t;

    vec_t vecs[$];
    int   fd_cnt;
    int   pops;
    int   seen_x[$];

    initial begin
        vecs = '{
            '{'h0305, 1, 0, 1,   5,   3, 1, 0},
            '{'h0102, 1, 0, 0,   0,   0, 0, 0},
            '{'h00FD, 1, 0, 0,   0,   0, 0, 0},
            '{'h0303, 1, 0, 1,   3,   3, 1, 0},
            '{'h03FC, 1, 0, 1, 252,   3, 1, 0},
            '{'h03FD, 1, 0, 0,   0,   0, 0, 0},
            '{'h0302, 1, 0, 0,   0,   0, 0, 0},
            '{'h7CFC, 1, 0, 1, 252, 124, 1, 0},
            '{'h7D10, 1, 0, 0,   0,   0, 0, 0},
            '{'h0203, 1, 0, 0,   0,   0, 0, 0},
            '{'h4080, 0, 0, 0,   0,   0, 0, 0},
            '{'h7CFC, 1, 1, 1, 252, 124, 1, 1},
            '{'h0102, 1, 1, 1,   0,   0, 0, 1},
            '{'h4080, 0, 1, 1,   0,   0, 0, 1}
        };

        // Reset state
        #2;
        chk("rst_outValid", int'(outValid), 0);
        chk("rst_fields", int'({outX, outY, outCorner, outLast}), 0);
        chk("rst_frameCount", int'(frameCount), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_frameDone", int'(frameDone), 0);
        do_reset();

        // Single-pixel vectors on an empty FIFO
        foreach (vecs[i]) begin
            step(1, vecs[i].c, vecs[i].a, vecs[i].fe, 1);
            chk("vec_vld", int'(outValid), int'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk("vec_x", int'(outX), vecs[i].x);
                chk("vec_y", int'(outY), vecs[i].y);
                chk("vec_corner", int'(outCorner), int'(vecs[i].corner));
                chk("vec_last", int'(outLast), int'(vecs[i].last));
            end
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 1);
        end
        chk("vec_overflow", int'(overflow), 0);

        // Frame end without a corner
        do_reset();
        fd_cnt = 0;
        for (int i = 0; i < 3; i++) step(1, 1, 'h0505 + i, 0, 1);
        step(1, 0, 'h0505, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            fd_cnt += int'(frameDone);
        end
        chk("noc_frameCount", int'(frameCount), 3);
        chk("noc_frameDone_pulses", fd_cnt, 1);

        // Frame end on a corner
        step(1, 1, 'h7CFC, 1, 1);
        chk("eoc_last", int'(outLast), 1);
        chk("eoc_frameCount", int'(frameCount), 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Backpressure and overflow, then ordered drain
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 1, 20 * 256 + 10 + i, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("bp_overflow", int'(overflow), 1);
        chk("bp_frameCount", int'(frameCount), 15);
        fd_cnt = 0;
        pops = 0;
        seen_x.delete();
        for (int k = 0; k < 18; k++) begin
            if (outValid) begin
                pops++;
                seen_x.push_back(outLast ? -1 : int'(outX));
            end
            step(0, 0, 0, 0, 1);
            fd_cnt += int'(frameDone);
        end
        chk("bp_pops", pops, 16);
        chk("bp_frameDone_pulses", fd_cnt, 1);
        foreach (seen_x[k]) chk("bp_order", seen_x[k], (k < 15) ? 10 + k : -1);

        // Full FIFO with simultaneous pop
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 1, 10 * 256 + 20 + i, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("full_overflow0", int'(overflow), 0);
        step(1, 1, 'h0A0A, 1, 1);
        chk("full_lastpush_overflow", int'(overflow), 0);
        step(1, 1, 'h0B0B, 0, 1);
        chk("full_corner_refused", int'(overflow), 1);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1);

        // Reset mid-drain
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 'h1010 + i, 0, 0);
        step(1, 1, 'h2020, 1, 0);
        chk("mid_frameCount", int'(frameCount), 5);
        outReady = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_outValid", int'(outValid), 0);
        chk("mid_frameCount0", int'(frameCount), 0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 1);
            fd_cnt += int'(frameDone);
        end
        chk("mid_no_frameDone", fd_cnt, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            bit v;
            bit c;
            bit fe;
            bit rdy;
            int a;
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 1) == 1);
            fe = ($urandom_range(0, 39) == 0);
            rdy = ((n / 200) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            a = $urandom_range(0, 32767);
            step(v, c, a, fe, rdy);
            if (n == 2000) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fd_corner_sink.md
# fd_corner_sink

Downstream stage of the FAST9 corner detector. Each cycle the controller finishes evaluating a reference pixel, this block takes the pixel's `isCorner` result and its 15-bit `refAddr`, and converts the address to (x, y). It drops corners inside the 3-pixel border, where the 16-pixel Bresenham circle is invalid, and queues accepted corners in a FIFO for a ready/valid consumer. It also appends an end-of-frame marker record and keeps per-frame corner counts and a sticky overflow flag.

## Interface
Parameters:
- `ADDR_W`, 15: pixel address width; matches `refAddr`.
- `X_W`, 8: log2 of image width; image is 2^X_W × 2^(ADDR_W−X_W), i.e. 256×128.
- `BORDER`, 3: excluded border width in pixels.
- `DEPTH`, 16: FIFO depth in entries; power of two, ≥ 4.
- `CNT_W`, 16: corner counter width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inValid`  in  1  one-cycle strobe: `isCorner`/`refAddr` hold a new result.
- `isCorner`  in  1  corner decision for `refAddr`.
- `refAddr`  in  ADDR_W  address of the evaluated reference pixel.
- `frameEnd`  in  1  qualified by `inValid`: this is the last pixel of the frame.
- `outValid`  out  1  FIFO head is valid.
- `outReady`  in  1  consumer accepts head when `outValid`=1.
- `outX`  out  X_W  corner x.
- `outY`  out  ADDR_W−X_W  corner y.
- `outCorner`  out  1  head record is a corner.
- `outLast`  out  1  head record closes a frame.
- `frameCount`  out  CNT_W  accepted corners of the last completed frame.
- `overflow`  out  1  sticky; a record was dropped.
- `frameDone`  out  1  one-cycle pulse when a record with `last`=1 is popped.

## Operation
- Address split:
  - x = `refAddr`[X_W−1:0]; y = `refAddr`[ADDR_W−1:X_W].
  - Interior: BORDER ≤ x ≤ 2^X_W−1−BORDER and BORDER ≤ y ≤ 2^(ADDR_W−X_W)−1−BORDER.
- Candidate = `inValid` & `isCorner` & interior.
- FIFO entry = {last, corner, x, y}. At most one push per cycle.
- Push rules:
  - Candidate, `frameEnd`=0: push {0,1,x,y} if slot available (see below).
  - `inValid` & `frameEnd`:
    - Candidate: push one entry {1,1,x,y}.
    - Otherwise: push marker {1,0,0,0}.
  - Other `inValid`: no push.
- Slot reservation, with occ' = occupancy − pop this cycle:
  - Non-last corner is pushed only if occ' ≤ DEPTH−2; one slot is always kept for the marker.
  - Last entry is pushed if occ' ≤ DEPTH−1.
  - Any refused push sets `overflow`. A refused push is not counted in `curCount`.
- Pop when `outValid` & `outReady`. `frameDone` asserts the cycle after popping an entry with last=1.
- Counters:
  - `curCount` increments on every accepted corner push, saturating at 2^CNT_W−1.
  - On `inValid` & `frameEnd`, `frameCount` ← `curCount` plus 1 if the last push is an accepted corner, saturating. Same cycle, `curCount` ← 0.
- `overflow` is cleared only by `reset`.
- A new frame may start in the cycle right after `frameEnd`; there is no stall toward upstream.

## Timing
- Reset values: `outValid`=0, `outX`/`outY`/`outCorner`/`outLast`=0, `frameCount`=0, `overflow`=0, `frameDone`=0. FIFO is empty and `curCount`=0.
- Latency: an entry pushed at edge N is presented at the outputs after edge N (`outValid`=1 from cycle N+1). Output fields come from registers.
- Head fields stay stable while `outValid`=1 & `outReady`=0.
- Push and pop in the same cycle are legal at any occupancy, including full: occupancy is unchanged and the freed slot counts toward occ'.
- Empty FIFO with push: no bypass; `outValid` rises one cycle later.
- Pointers wrap modulo DEPTH; occupancy has log2(DEPTH)+1 bits.
- `reset` mid-frame or mid-drain aborts immediately and asynchronously: queued entries are lost and no `frameDone` is issued.
- `frameEnd` without `inValid` is ignored.

## Test plan
- Interior corner and border rejection:
  - Stimulus: `refAddr`=0x0305 (x=5, y=3), then 0x0102 (x=2, y=1), then 0x00FD (x=253, y=0). All with `isCorner`=1, `outReady`=1.
  - Response: exactly one record {x=5, y=3, corner=1, last=0}, valid one cycle after its strobe. `overflow`=0.
- Frame end without a corner:
  - Stimulus: 3 interior corners, then `inValid`=1, `frameEnd`=1, `isCorner`=0.
  - Response: 3 corner records, then marker {corner=0, last=1}. `frameCount`=3. `frameDone` pulses once, the cycle after the marker is popped.
- Frame end on a corner:
  - Stimulus: `frameEnd` pixel `refAddr`=0x7CFC (x=252, y=124), `isCorner`=1.
  - Response: single record {252, 124, corner=1, last=1}. `frameCount` includes it.
- Backpressure and overflow:
  - Stimulus: `outReady`=0, 20 interior corners, then `frameEnd`.
  - Response: 15 corners queued, `overflow`=1, marker queued as the 16th entry.
  - After `outReady`=1: 16 records drain in order, `frameDone` pulses once.
- Simultaneous push/pop at full, and reset mid-drain:
  - Stimulus: FIFO at 16 entries, last entry pushed with `outReady`=1 → no new overflow.
  - Stimulus: assert `reset` with 5 entries queued.
  - Response: `outValid`=0 and `frameCount`=0 immediately; no `frameDone`.
